// File: rtl/key_cond_pkg.sv
// Shared types, default constants and width helper for the key conditioner.
// Also used by other board-input blocks that need the same counter sizing.
package key_cond_pkg;

    localparam int DEF_DEB_CYCLES    = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_HELD   = 2'b01;
    localparam logic [1:0] ST_REPEAT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        HELD   = ST_HELD,
        REPEAT = ST_REPEAT
    } rep_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
// Reset value is a parameter so idle-high and idle-low inputs can share it.
module sync_2ff #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: sync, debounce, press/release strobes and optional
// auto-repeat (compiled in when KEY_AUTOREPEAT_EN is defined).
//
// state  | meaning
// IDLE   | key released (or repeat disabled), waiting for a debounced press
// HELD   | key pressed, counting the initial repeat delay
// REPEAT | key still held, emitting o_repeat every REPEAT_PERIOD cycles
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DEB_W = cnt_w(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEB_CYCLES - 1);

    logic             key_s;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;
    logic             rise_evt;
    logic             fall_evt;

    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (~i_key_n),
        .o_q   (key_s)
    );

    // The same terminal-count condition drives o_level, the strobes and the FSM,
    // so every consumer sees the edge in the same cycle.
    assign deb_done = (key_s != o_level) && (deb_cnt == DEB_TC);
    assign rise_evt = deb_done & key_s;
    assign fall_evt = deb_done & ~key_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            deb_cnt   <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= rise_evt;
            o_release <= fall_evt;
            if (key_s == o_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TC) begin
                o_level <= key_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = cnt_w(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_TC  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_TC = REP_W'(REPEAT_PERIOD - 1);

    rep_state_e       state;
    logic [REP_W-1:0] rep_cnt;

    // Release is checked before the terminal count so a release always wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            rep_cnt  <= '0;
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= 1'b0;
            case (state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (rise_evt) begin
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (fall_evt) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end else if (rep_cnt == DELAY_TC) begin
                        o_repeat <= 1'b1;
                        rep_cnt  <= '0;
                        state    <= REPEAT;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall_evt) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end else if (rep_cnt == PERIOD_TC) begin
                        o_repeat <= 1'b1;
                        rep_cnt  <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                end
            endcase
        end
    end
`else
    logic unused_rep_cfg;

    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign o_repeat       = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; repeat expectations follow whether KEY_AUTOREPEAT_EN is set.
module tb_key_conditioner;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_key_n;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_repeat;

    int total = 0;
    int bad   = 0;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    key_conditioner #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key_n   (i_key_n),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic lv, input logic pr,
                           input logic rl, input logic rp);
        chk({tag, ".level"},   o_level,   lv);
        chk({tag, ".press"},   o_press,   pr);
        chk({tag, ".release"}, o_release, rl);
        chk({tag, ".repeat"},  o_repeat,  rp);
    endtask

    // j = cycles after the o_press cycle; pulses at 20, 28, 36, ...
    function automatic logic rep_exp(input int j);
        return REP_EN && (j >= 20) && (((j - 20) % 8) == 0);
    endfunction

    task automatic cyc();
        @(negedge i_clk);
    endtask

    // Key goes down now; o_press expected on the sixth edge.
    task automatic press_seq(input string tag);
        i_key_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk_all({tag, ".wait"}, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        chk_all({tag, ".edge"}, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic hold(input string tag, input int j_from, input int j_to);
        for (int j = j_from; j <= j_to; j++) begin
            cyc();
            chk_all(tag, 1'b1, 1'b0, 1'b0, rep_exp(j));
        end
    endtask

    // Key released after hold cycle j0; o_release on the sixth edge, never with o_repeat.
    task automatic release_seq(input string tag, input int j0);
        i_key_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk_all({tag, ".wait"}, 1'b1, 1'b0, 1'b0, rep_exp(j0 + k));
        end
        cyc();
        chk_all({tag, ".edge"}, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_all({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_key_n = 1'b1;
        repeat (3) cyc();
        chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Bounce: 3 low / 2 high, five times, then settle released.
        for (int r = 0; r < 5; r++) begin
            i_key_n = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk_all("bounce_lo", 1'b0, 1'b0, 1'b0, 1'b0);
            end
            i_key_n = 1'b1;
            for (int k = 0; k < 2; k++) begin
                cyc();
                chk_all("bounce_hi", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_all("bounce_settle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clean press, 60-cycle hold with repeats, release.
        press_seq("press");
        hold("hold60", 1, 60);
        release_seq("rel60", 60);

        // Release lands exactly where a repeat would have fired (+28).
        press_seq("press_prio");
        hold("hold_prio", 1, 22);
        release_seq("rel_prio", 22);

        // Reset mid-repeat with the key still held.
        press_seq("press_rst");
        hold("hold_rst", 1, 25);
        i_rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            cyc();
            chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        i_rst = 1'b0;
        press_seq("repress");
        hold("hold_after_rst", 1, 25);
        release_seq("rel_after_rst", 25);

        // Long 100-cycle hold.
        press_seq("press100");
        hold("hold100", 1, 100);
        release_seq("rel100", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
